cic_comb_dump: RTL and testbench
================================

Name: cic_comb_dump

Overview:
- Decimating comb (differentiator) section that consumes the full-rate output of a 32-bit wrapping integrator chain.
- Dumps one of every `rate` input samples, then runs the dumped sample through N_STAGES pipelined first-difference stages (differential delay 1).
- Emits one decimated, strobed result per dump.
- Sits between the integrator accumulators and the downstream half-band/output packing logic in the receive path.

Parameters:
- WIDTH, 32, sample width of data_in, internal registers and data_out.
- N_STAGES, 4, number of comb stages; legal range 1..6.
- RATE_W, 8, width of the decimation rate input.

Ports:
- clock  input  1  sole clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  high = run; low = synchronous clear of counter and comb state.
- rate  input  RATE_W  decimation factor; 0 is treated as 1.
- strobe_in  input  1  one-cycle qualifier; data_in is valid this cycle.
- data_in  input  WIDTH  integrator output, two's complement, wrapping.
- strobe_out  output  1  one-cycle pulse; data_out is new this cycle.
- data_out  output  WIDTH  decimated comb output, two's complement.

Behaviour:
- Clocking/reset (already decided): one clock, named clock; reset is synchronous and active-high, named reset.
- Reset values:
  - data_out = 0, strobe_out = 0.
  - All comb delay registers = 0, all stage valid flags = 0.
  - Decimation counter = max(rate,1)-1.
- Decimation counter:
  - Decrements on each strobe_in while enable is high.
  - When strobe_in arrives with counter == 0: dump data_in into stage-0 register, set valid_0, reload counter with max(rate,1)-1.
  - A rate change takes effect only at the next reload. It never truncates the current count.
- Comb stages, k = 1..N_STAGES, one register stage each, on valid_(k-1):
  - diff_k <= in_k - dly_k
  - dly_k <= in_k
  - valid_k <= 1; otherwise valid_k <= 0.
- Arithmetic is modulo 2^WIDTH with no saturation and no overflow flag. Wrap is required for CIC correctness.
- Output and latency:
  - data_out <= diff_N when valid_N; held otherwise.
  - strobe_out = registered valid_N.
  - strobe_out asserts exactly N_STAGES+1 cycles after the dumping strobe_in edge.
- Throughput: fully pipelined. Dumps on consecutive cycles (rate=1, strobe_in every cycle) produce strobe_out every cycle; there are no stalls and no backpressure.
- strobe_in low: counter and comb state hold.
- enable low:
  - Counter reloads to max(rate,1)-1.
  - Delay registers and valid flags clear; in-flight samples are discarded.
  - No strobe_out is produced; data_out holds its last value.
- reset and enable low together: reset wins, so data_out = 0.
- Reset mid-pipeline discards in-flight samples. The first dump after release uses zeroed delays.

Decomposition:
- Shared package: WIDTH default, N_STAGES max (6), RATE_W default, and the rate-normalisation function max(rate,1)-1.
- One natural sub-module, cic_comb_stage: one difference stage with valid in/out, delay register and clear input. Instantiate it N_STAGES times via generate.
- The decimation counter and output register stay in the top level.

Test Plan:
- Impulse: rate=1, strobe_in every cycle, data_in = 1 then 0s -> data_out 1, -4, 6, -4, 1, then 0; first strobe_out 5 cycles after the impulse edge.
- Step: rate=1, data_in=5 constant every cycle -> 5, -15, 15, -5, then 0 forever.
- Decimation: rate=4, strobe_in every cycle, data_in = 0,1,2,... -> dumps at inputs 3,7,11,15,...; outputs 3, -5, 1, 1, then 0; strobe_out spacing exactly 4 cycles.
- Wrap: rate=1, data_in = 0x7FFFFFFE + n -> outputs 0x7FFFFFFE, 0x80000007, 0x7FFFFFF8, 0x80000003, then 0.
- Edge/control:
  - rate=0 behaves identically to rate=1.
  - Change rate 4->2 mid-count: current period still completes at 4, the next one is 2.
  - Sparse strobe_in (every 3rd cycle) with rate=2: one dump per 2 strobes.
- Clear: assert enable=0 (then separately reset=1) while 3 samples are in flight -> no strobe_out; after release an impulse reproduces the impulse-test sequence exactly; reset leaves data_out=0, enable-low leaves it held.

Source files
------------

// File: rtl/cic_comb_dump_pkg.sv
// Shared constants and the rate normalisation used by the CIC comb/decimator.
package cic_comb_dump_pkg;

    localparam int unsigned WIDTH_DEFAULT  = 32;
    localparam int unsigned N_STAGES_MAX   = 6;
    localparam int unsigned RATE_W_DEFAULT = 8;

    // A rate of 0 is treated as 1, so the reload value is max(rate,1)-1.
    function automatic int unsigned rate_reload(input int unsigned rate);
        return (rate == 0) ? 0 : rate - 1;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One first-difference comb stage (differential delay 1) with a valid flag.
module cic_comb_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] sample,
    input  logic             sample_valid,
    output logic [WIDTH-1:0] diff,
    output logic             diff_valid
);

    logic [WIDTH-1:0] dly_q;
    logic [WIDTH-1:0] diff_q;
    logic             valid_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            dly_q   <= '0;
            diff_q  <= '0;
            valid_q <= 1'b0;
        end else if (sample_valid) begin
            // Modulo-2^WIDTH subtraction; the wrap is what makes the CIC work.
            diff_q  <= sample - dly_q;
            dly_q   <= sample;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign diff       = diff_q;
    assign diff_valid = valid_q;

endmodule

// File: rtl/cic_comb_dump.sv
// Decimating comb section: dumps one of every `rate` strobed samples into N pipelined
// first-difference stages and emits one strobed result per dump.
module cic_comb_dump
    import cic_comb_dump_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEFAULT,
    parameter int unsigned N_STAGES = 4,
    parameter int unsigned RATE_W   = RATE_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [RATE_W-1:0] rate,
    input  logic              strobe_in,
    input  logic [WIDTH-1:0]  data_in,
    output logic              strobe_out,
    output logic [WIDTH-1:0]  data_out
);

    if (N_STAGES < 1 || N_STAGES > N_STAGES_MAX) begin : g_bad_stages
        $error("cic_comb_dump: N_STAGES out of range");
    end

    logic [RATE_W-1:0] cnt_q, cnt_d;
    logic [RATE_W-1:0] reload;
    logic              dump;
    logic [WIDTH-1:0]  s0_data_q;
    logic              s0_valid_q;
    logic [WIDTH-1:0]  chain_data [N_STAGES+1];
    logic [N_STAGES:0] chain_valid;
    logic [WIDTH-1:0]  data_q;
    logic              strobe_q;

    assign reload = RATE_W'(rate_reload(32'(rate)));

    // The live rate is only sampled at reload, so a change never truncates a count.
    always_comb begin
        cnt_d = cnt_q;
        dump  = 1'b0;
        if (strobe_in) begin
            if (cnt_q == '0) begin
                dump  = 1'b1;
                cnt_d = reload;
            end else begin
                cnt_d = cnt_q - RATE_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            cnt_q      <= reload;
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            s0_valid_q <= dump;
            if (dump) begin
                s0_data_q <= data_in;
            end
        end
    end

    assign chain_data[0]  = s0_data_q;
    assign chain_valid[0] = s0_valid_q;

    for (genvar k = 1; k <= N_STAGES; k++) begin : g_stage
        cic_comb_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clock       (clock),
            .reset       (reset),
            .clear       (!enable),
            .sample      (chain_data[k-1]),
            .sample_valid(chain_valid[k-1]),
            .diff        (chain_data[k]),
            .diff_valid  (chain_valid[k])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q   <= '0;
            strobe_q <= 1'b0;
        end else if (!enable) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= chain_valid[N_STAGES];
            if (chain_valid[N_STAGES]) begin
                data_q <= chain_data[N_STAGES];
            end
        end
    end

    assign data_out   = data_q;
    assign strobe_out = strobe_q;

endmodule

// File: tb/tb_cic_comb_dump.sv
// Self-checking bench for cic_comb_dump: directed vector table, corner sequences and
// randomized traffic against a binomial-sum reference model.
module tb_cic_comb_dump;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int RW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [RW-1:0] rate;
    logic          strobe_in;
    logic [W-1:0]  data_in;
    logic          strobe_out;
    logic [W-1:0]  data_out;

    always #5 clock = ~clock;

    cic_comb_dump #(
        .WIDTH   (W),
        .N_STAGES(N),
        .RATE_W  (RW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .rate      (rate),
        .strobe_in (strobe_in),
        .data_in   (data_in),
        .strobe_out(strobe_out),
        .data_out  (data_out)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: strobes left before the next dump, history of dumped samples,
    // and the results scheduled for their output cycle.
    typedef struct {
        int           due;
        logic [W-1:0] val;
    } pend_t;

    int unsigned  m_cnt;
    logic [W-1:0] m_hist[$];
    pend_t        m_pend[$];
    logic         m_strobe = 1'b0;
    logic [W-1:0] m_data   = '0;

    logic [W-1:0] seen_val[$];
    int           seen_cyc[$];

    function automatic int unsigned period(input logic [RW-1:0] r);
        return (r == 0) ? 1 : int'(r);
    endfunction

    // N-th backward difference = sum_k (-1)^k C(N,k) x[n-k], missing history is zero.
    function automatic logic [W-1:0] nth_diff();
        logic [W-1:0] acc = '0;
        int coef = 1;
        int sz = m_hist.size();
        for (int k = 0; k <= N; k++) begin
            if (k < sz) begin
                if (k % 2 == 0) acc = acc + W'(coef) * m_hist[sz-1-k];
                else            acc = acc - W'(coef) * m_hist[sz-1-k];
            end
            coef = coef * (N - k) / (k + 1);
        end
        return acc;
    endfunction

    task automatic model_edge();
        if (reset || !enable) begin
            m_cnt = period(rate) - 1;
            m_hist.delete();
            m_pend.delete();
            m_strobe = 1'b0;
            if (reset) m_data = '0;
        end else begin
            m_strobe = 1'b0;
            if (m_pend.size() > 0 && m_pend[0].due == cyc) begin
                m_strobe = 1'b1;
                m_data   = m_pend[0].val;
                void'(m_pend.pop_front());
            end
            if (strobe_in) begin
                if (m_cnt == 0) begin
                    m_hist.push_back(data_in);
                    if (m_hist.size() > N + 1) void'(m_hist.pop_front());
                    m_pend.push_back('{cyc + N + 1, nth_diff()});
                    m_cnt = period(rate) - 1;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        model_edge();
        #1;
        chk("strobe_out", W'(strobe_out), W'(m_strobe));
        chk("data_out", data_out, m_data);
        if (strobe_out === 1'b1) begin
            seen_val.push_back(data_out);
            seen_cyc.push_back(cyc);
        end
    endtask

    task automatic expect_seen(input string name, input int idx, input logic [W-1:0] exp);
        if (idx >= seen_val.size()) begin
            checks++;
            errors++;
            $display("FAIL %s[%0d]: no output seen, expected %h", name, idx, exp);
        end else begin
            chk($sformatf("%s[%0d]", name, idx), seen_val[idx], exp);
        end
    endtask

    task automatic expect_gap(input string name, input int a, input int b, input int exp);
        if (b >= seen_cyc.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: output %0d missing, expected gap %0d", name, b, exp);
        end else begin
            chk(name, W'(seen_cyc[b] - seen_cyc[a]), W'(exp));
        end
    endtask

    task automatic do_reset(input logic [RW-1:0] r);
        reset     = 1'b1;
        enable    = 1'b1;
        strobe_in = 1'b0;
        data_in   = '0;
        rate      = r;
        tick();
        tick();
        chk("reset_strobe", W'(strobe_out), '0);
        chk("reset_data", data_out, '0);
        reset = 1'b0;
        seen_val.delete();
        seen_cyc.delete();
    endtask

    typedef struct {
        string         name;
        logic [RW-1:0] rate;
        logic [W-1:0]  base;
        logic [W-1:0]  step;
        bit            impulse;
        logic [W-1:0]  exp[5];
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        int in_cyc[40];
        int d;
        do_reset(v.rate);
        for (int i = 0; i < 40; i++) begin
            strobe_in = 1'b1;
            data_in   = v.impulse ? W'(i == 0) : v.base + v.step * W'(i);
            tick();
            in_cyc[i] = cyc;
        end
        strobe_in = 1'b0;
        repeat (8) tick();
        for (int k = 0; k < 5; k++) expect_seen(v.name, k, v.exp[k]);
        expect_seen(v.name, 5, '0);
        d = int'(period(v.rate)) - 1;
        if (seen_cyc.size() > 0) begin
            chk({v.name, "_latency"}, W'(seen_cyc[0] - in_cyc[d]), W'(N + 1));
        end else begin
            checks++;
            errors++;
            $display("FAIL %s_latency: no output seen, expected %0d", v.name, N + 1);
        end
        expect_gap({v.name, "_spacing"}, 0, 1, int'(period(v.rate)));
    endtask

    task automatic impulse_check(input string name);
        seen_val.delete();
        seen_cyc.delete();
        for (int i = 0; i < 12; i++) begin
            strobe_in = 1'b1;
            data_in   = W'(i == 0);
            tick();
        end
        strobe_in = 1'b0;
        repeat (6) tick();
        for (int k = 0; k < 5; k++) expect_seen(name, k, vecs[0].exp[k]);
        expect_seen(name, 5, '0);
    endtask

    task automatic clear_test(input bit use_reset);
        string nm;
        nm = use_reset ? "clear_reset" : "clear_enable";
        do_reset(8'd1);
        strobe_in = 1'b1;
        data_in   = 32'd7;
        tick();
        strobe_in = 1'b0;
        repeat (7) tick();
        chk({nm, "_pre"}, data_out, 32'd7);
        seen_val.delete();
        seen_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            strobe_in = 1'b1;
            data_in   = W'(2 << i);
            tick();
        end
        strobe_in = 1'b0;
        enable    = 1'b0;
        reset     = use_reset;
        repeat (2) tick();
        enable = 1'b1;
        reset  = 1'b0;
        repeat (8) tick();
        chk({nm, "_no_strobe"}, W'(seen_val.size()), '0);
        chk({nm, "_held"}, data_out, use_reset ? 32'd0 : 32'd7);
        impulse_check({nm, "_impulse"});
    endtask

    initial begin
        int in_cyc[20];

        vecs[0] = '{"impulse", 8'd1, 32'd0, 32'd0, 1'b1,
                    '{32'd1, 32'hFFFF_FFFC, 32'd6, 32'hFFFF_FFFC, 32'd1}};
        vecs[1] = '{"step", 8'd1, 32'd5, 32'd0, 1'b0,
                    '{32'd5, 32'hFFFF_FFF1, 32'd15, 32'hFFFF_FFFB, 32'd0}};
        vecs[2] = '{"decim4", 8'd4, 32'd0, 32'd1, 1'b0,
                    '{32'd3, 32'hFFFF_FFFB, 32'd1, 32'd1, 32'd0}};
        vecs[3] = '{"wrap", 8'd1, 32'h7FFF_FFFE, 32'd1, 1'b0,
                    '{32'h7FFF_FFFE, 32'h8000_0007, 32'h7FFF_FFF8, 32'h8000_0003, 32'd0}};
        vecs[4] = '{"rate0", 8'd0, 32'd0, 32'd0, 1'b1,
                    '{32'd1, 32'hFFFF_FFFC, 32'd6, 32'hFFFF_FFFC, 32'd1}};

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Rate 4 -> 2 after two strobes: the running period still completes at 4.
        do_reset(8'd4);
        for (int i = 0; i < 20; i++) begin
            if (i == 2) rate = 8'd2;
            strobe_in = 1'b1;
            data_in   = W'(i * 3);
            tick();
            in_cyc[i] = cyc;
        end
        strobe_in = 1'b0;
        repeat (8) tick();
        if (seen_cyc.size() > 0) begin
            chk("ratechg_first", W'(seen_cyc[0] - in_cyc[3]), W'(N + 1));
        end else begin
            checks++;
            errors++;
            $display("FAIL ratechg_first: no output seen, expected first dump at input 3");
        end
        expect_gap("ratechg_gap", 0, 1, 2);

        // Strobe every 3rd cycle at rate 2: a dump every 6 cycles.
        do_reset(8'd2);
        for (int i = 0; i < 36; i++) begin
            strobe_in = (i % 3 == 0);
            data_in   = W'(i);
            tick();
        end
        strobe_in = 1'b0;
        repeat (8) tick();
        expect_gap("sparse_gap1", 0, 1, 6);
        expect_gap("sparse_gap2", 1, 2, 6);

        clear_test(1'b0);
        clear_test(1'b1);

        // Randomized traffic against the model.
        do_reset(8'd3);
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            enable    = ($urandom_range(0, 59) != 0);
            strobe_in = ($urandom_range(0, 3) != 0);
            data_in   = $urandom;
            if ($urandom_range(0, 39) == 0) rate = RW'($urandom_range(0, 6));
            tick();
        end
        reset     = 1'b0;
        enable    = 1'b1;
        strobe_in = 1'b0;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
